mem_arbiter: RTL

Shares one single-ported synchronous memory between the CPU instruction-fetch port, the CPU data port and the program loader. Sits between the `cpu` ports (PC/Instr, ALUResult/WriteData/ReadData/ByteEn) and the unified RAM. It does four things:
- decides one winner per cycle;
- returns read data to the owner one cycle later;
- protects fetch from starvation with a wait counter;
- lets the loader lock the bus for burst writes.

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for CPU fetch, CPU data and program loader.
// One combinational grant per cycle, one-cycle read return, fetch anti-starvation and loader bus lock.
module mem_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    input  logic        l_req,
    input  logic        l_lock,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_gnt,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic [31:0] m_rdata,
    output logic        locked
);

    typedef enum logic {SHARED, LOCKED} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t     state_q, state_d;
    owner_t     owner_q, owner_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       promoted;

    assign promoted = (wait_cnt_q == MAX_WAIT_C);
    assign locked   = (state_q == LOCKED);

    // Grant decision: loader first, then promoted fetch, data, plain fetch.
    always_comb begin
        l_gnt = 1'b0;
        d_gnt = 1'b0;
        i_gnt = 1'b0;
        if (!reset) begin
            if (state_q == LOCKED) begin
                l_gnt = l_req;
            end else if (l_req) begin
                l_gnt = 1'b1;
            end else if (i_req && promoted) begin
                i_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_be    = '0;
        if (l_gnt) begin
            m_en    = 1'b1;
            m_we    = 1'b1;
            m_addr  = l_addr;
            m_wdata = l_wdata;
            m_be    = 4'hF;
        end else if (d_gnt) begin
            m_en    = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_be    = d_be;
        end else if (i_gnt) begin
            m_en    = 1'b1;
            m_addr  = i_addr;
            m_be    = 4'hF;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = OWN_NONE;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            SHARED:  if (l_gnt && l_lock) state_d = LOCKED;
            LOCKED:  if (!l_req || !l_lock) state_d = SHARED;
            default: state_d = SHARED;
        endcase
        if (i_gnt) begin
            owner_d = OWN_FETCH;
        end else if (d_gnt && !d_we) begin
            owner_d = OWN_DATA;
        end
        // Saturate rather than wrap so a promoted fetch stays promoted while the loader holds the bus.
        if (i_gnt || !i_req) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SHARED;
            owner_q    <= OWN_NONE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Return path is gated by reset so a read in flight when reset arrives never surfaces.
    assign i_rvalid = !reset && (owner_q == OWN_FETCH);
    assign d_rvalid = !reset && (owner_q == OWN_DATA);
    assign i_rdata  = i_rvalid ? m_rdata : 32'h0;
    assign d_rdata  = d_rvalid ? m_rdata : 32'h0;

endmodule
